// File: rtl/rv32i_types.sv
// Shared core types for the physical register file slice.
// Holds the default physical-register index width, the index type built from
// it, and the index of the hardwired-zero register p0.
package rv32i_types;

  localparam int PHYS_REG_BITS_DEF = 6;

  typedef logic [PHYS_REG_BITS_DEF-1:0] phys_reg_t;

  localparam phys_reg_t PREG_ZERO = '0;

endpackage

// File: rtl/preg_bypass_mux.sv
// Writeback-to-read bypass selector for one read index.
// Ports:
//   rd_s   : read index being looked up
//   wb_we  : per-port writeback enable
//   wb_s   : flattened writeback indices (port i at [i*PHYS_REG_BITS +: PHYS_REG_BITS])
//   wb_v   : flattened writeback data (port i at [i*32 +: 32])
//   hit    : some enabled writeback targets rd_s this cycle (never for p0)
//   data   : data of the highest-numbered matching writeback port
module preg_bypass_mux
  import rv32i_types::*;
#(
  parameter int PHYS_REG_BITS = PHYS_REG_BITS_DEF,
  parameter int NUM_WB        = 2
) (
  input  logic [PHYS_REG_BITS-1:0]        rd_s,
  input  logic [NUM_WB-1:0]               wb_we,
  input  logic [NUM_WB*PHYS_REG_BITS-1:0] wb_s,
  input  logic [NUM_WB*32-1:0]            wb_v,
  output logic                            hit,
  output logic [31:0]                     data
);

  // Ascending scan so a later (higher) port overrides an earlier match.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int i = 0; i < NUM_WB; i++) begin
      if (wb_we[i] && (wb_s[i*PHYS_REG_BITS +: PHYS_REG_BITS] == rd_s) &&
          (rd_s != PHYS_REG_BITS'(PREG_ZERO))) begin
        hit  = 1'b1;
        data = wb_v[i*32 +: 32];
      end
    end
  end

endmodule

// File: rtl/phys_regfile_mp.sv
// Multi-ported physical register file with a per-register ready table.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   wb_we/wb_s/wb_v     : NUM_WB writeback ports (enable, flattened index, flattened data)
//   alloc_en/alloc_s    : NUM_ALLOC dispatch allocation ports, clear the ready bit
//   rs1_s/rs2_s         : NUM_RD read-port pairs, flattened indices
//   rs1_v/rs2_v         : read data, combinational (REG_READ=0) or registered (REG_READ=1)
//   rs1_rdy/rs2_rdy     : ready bit of the addressed register, always combinational
//   wb_conflict         : two enabled writebacks hit the same nonzero register last cycle
module phys_regfile_mp
  import rv32i_types::*;
#(
  parameter int PHYS_REG_BITS = PHYS_REG_BITS_DEF,
  parameter int NUM_RD        = 2,
  parameter int NUM_WB        = 2,
  parameter int NUM_ALLOC     = 1,
  parameter int REG_READ      = 0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_WB-1:0]                  wb_we,
  input  logic [NUM_WB*PHYS_REG_BITS-1:0]    wb_s,
  input  logic [NUM_WB*32-1:0]               wb_v,
  input  logic [NUM_ALLOC-1:0]               alloc_en,
  input  logic [NUM_ALLOC*PHYS_REG_BITS-1:0] alloc_s,
  input  logic [NUM_RD*PHYS_REG_BITS-1:0]    rs1_s,
  input  logic [NUM_RD*PHYS_REG_BITS-1:0]    rs2_s,
  output logic [NUM_RD*32-1:0]               rs1_v,
  output logic [NUM_RD*32-1:0]               rs2_v,
  output logic [NUM_RD-1:0]                  rs1_rdy,
  output logic [NUM_RD-1:0]                  rs2_rdy,
  output logic                               wb_conflict
);

  localparam int NUM_PREGS = 2 ** PHYS_REG_BITS;
  localparam logic [PHYS_REG_BITS-1:0] PZ = PHYS_REG_BITS'(PREG_ZERO);

  logic [31:0]          regs [NUM_PREGS];
  logic [NUM_PREGS-1:0] ready;
  logic                 conflict_next;
  logic [NUM_RD*32-1:0] rs1_comb;
  logic [NUM_RD*32-1:0] rs2_comb;

  // Writebacks are applied in ascending port order and allocations after
  // them, so the highest writeback port wins the data and an allocation of
  // the same register leaves it not-ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_PREGS; p++) regs[p] <= '0;
      ready <= '1;
    end else begin
      for (int i = 0; i < NUM_WB; i++) begin
        if (wb_we[i] && (wb_s[i*PHYS_REG_BITS +: PHYS_REG_BITS] != PZ)) begin
          regs[wb_s[i*PHYS_REG_BITS +: PHYS_REG_BITS]]  <= wb_v[i*32 +: 32];
          ready[wb_s[i*PHYS_REG_BITS +: PHYS_REG_BITS]] <= 1'b1;
        end
      end
      for (int j = 0; j < NUM_ALLOC; j++) begin
        if (alloc_en[j] && (alloc_s[j*PHYS_REG_BITS +: PHYS_REG_BITS] != PZ)) begin
          ready[alloc_s[j*PHYS_REG_BITS +: PHYS_REG_BITS]] <= 1'b0;
        end
      end
    end
  end

  // Any pair of enabled writeback ports aimed at the same nonzero register.
  always_comb begin
    conflict_next = 1'b0;
    for (int i = 0; i < NUM_WB; i++) begin
      for (int j = i + 1; j < NUM_WB; j++) begin
        if (wb_we[i] && wb_we[j] &&
            (wb_s[i*PHYS_REG_BITS +: PHYS_REG_BITS] == wb_s[j*PHYS_REG_BITS +: PHYS_REG_BITS]) &&
            (wb_s[i*PHYS_REG_BITS +: PHYS_REG_BITS] != PZ)) begin
          conflict_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wb_conflict <= 1'b0;
    else        wb_conflict <= conflict_next;
  end

  // Per read port: p0 reads as zero/ready, a same-cycle writeback is
  // forwarded as ready (regardless of any allocation), else the array.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [PHYS_REG_BITS-1:0] s1, s2;
    logic                     hit1, hit2;
    logic [31:0]              byp1, byp2;

    assign s1 = rs1_s[k*PHYS_REG_BITS +: PHYS_REG_BITS];
    assign s2 = rs2_s[k*PHYS_REG_BITS +: PHYS_REG_BITS];

    preg_bypass_mux #(.PHYS_REG_BITS(PHYS_REG_BITS), .NUM_WB(NUM_WB)) u_byp1 (
      .rd_s(s1), .wb_we(wb_we), .wb_s(wb_s), .wb_v(wb_v), .hit(hit1), .data(byp1)
    );
    preg_bypass_mux #(.PHYS_REG_BITS(PHYS_REG_BITS), .NUM_WB(NUM_WB)) u_byp2 (
      .rd_s(s2), .wb_we(wb_we), .wb_s(wb_s), .wb_v(wb_v), .hit(hit2), .data(byp2)
    );

    assign rs1_comb[k*32 +: 32] = (s1 == PZ) ? 32'h0 : (hit1 ? byp1 : regs[s1]);
    assign rs2_comb[k*32 +: 32] = (s2 == PZ) ? 32'h0 : (hit2 ? byp2 : regs[s2]);
    assign rs1_rdy[k] = (s1 == PZ) || hit1 || ready[s1];
    assign rs2_rdy[k] = (s2 == PZ) || hit2 || ready[s2];
  end

  if (REG_READ != 0) begin : g_reg_read
    logic [NUM_RD*32-1:0] rs1_q, rs2_q;

    // Registered read: capture this cycle's array-plus-bypass view.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rs1_q <= '0;
        rs2_q <= '0;
      end else begin
        rs1_q <= rs1_comb;
        rs2_q <= rs2_comb;
      end
    end

    assign rs1_v = rs1_q;
    assign rs2_v = rs2_q;
  end else begin : g_comb_read
    assign rs1_v = rs1_comb;
    assign rs2_v = rs2_comb;
  end

endmodule

// File: tb/tb_phys_regfile_mp.sv
// Self-checking bench for phys_regfile_mp. Two instances share all inputs:
// one with combinational reads, one with registered reads.
module tb_phys_regfile_mp;
  import rv32i_types::*;

  localparam int B  = 6;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int NA = 1;
  localparam int NP = 2 ** B;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // Unpacked stimulus, packed onto the DUT ports below.
  logic        wb_we_a  [NW];
  phys_reg_t   wb_s_a   [NW];
  logic [31:0] wb_v_a   [NW];
  logic        alloc_en_a [NA];
  phys_reg_t   alloc_s_a  [NA];
  phys_reg_t   rs1_s_a  [NR];
  phys_reg_t   rs2_s_a  [NR];

  logic [NW-1:0]    wb_we;
  logic [NW*B-1:0]  wb_s;
  logic [NW*32-1:0] wb_v;
  logic [NA-1:0]    alloc_en;
  logic [NA*B-1:0]  alloc_s;
  logic [NR*B-1:0]  rs1_s, rs2_s;

  always_comb begin
    for (int i = 0; i < NW; i++) begin
      wb_we[i]         = wb_we_a[i];
      wb_s[i*B +: B]   = wb_s_a[i];
      wb_v[i*32 +: 32] = wb_v_a[i];
    end
    for (int j = 0; j < NA; j++) begin
      alloc_en[j]       = alloc_en_a[j];
      alloc_s[j*B +: B] = alloc_s_a[j];
    end
    for (int k = 0; k < NR; k++) begin
      rs1_s[k*B +: B] = rs1_s_a[k];
      rs2_s[k*B +: B] = rs2_s_a[k];
    end
  end

  logic [NR*32-1:0] rs1_v0, rs2_v0, rs1_v1, rs2_v1;
  logic [NR-1:0]    rs1_rdy0, rs2_rdy0, rs1_rdy1, rs2_rdy1;
  logic             conf0, conf1;

  phys_regfile_mp #(.PHYS_REG_BITS(B), .NUM_RD(NR), .NUM_WB(NW), .NUM_ALLOC(NA), .REG_READ(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .wb_we(wb_we), .wb_s(wb_s), .wb_v(wb_v),
    .alloc_en(alloc_en), .alloc_s(alloc_s), .rs1_s(rs1_s), .rs2_s(rs2_s),
    .rs1_v(rs1_v0), .rs2_v(rs2_v0), .rs1_rdy(rs1_rdy0), .rs2_rdy(rs2_rdy0),
    .wb_conflict(conf0)
  );

  phys_regfile_mp #(.PHYS_REG_BITS(B), .NUM_RD(NR), .NUM_WB(NW), .NUM_ALLOC(NA), .REG_READ(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .wb_we(wb_we), .wb_s(wb_s), .wb_v(wb_v),
    .alloc_en(alloc_en), .alloc_s(alloc_s), .rs1_s(rs1_s), .rs2_s(rs2_s),
    .rs1_v(rs1_v1), .rs2_v(rs2_v1), .rs1_rdy(rs1_rdy1), .rs2_rdy(rs2_rdy1),
    .wb_conflict(conf1)
  );

  int checks = 0;
  int errors = 0;
  logic check_en = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: architectural contents, ready table, conflict flag and
  // the values a registered read port must be showing.
  logic [31:0] data_m  [NP];
  logic        ready_m [NP];
  logic        conflict_m;
  logic [31:0] reg1_m [NR];
  logic [31:0] reg2_m [NR];

  function automatic logic [31:0] exp_val(input phys_reg_t s);
    logic [31:0] r;
    if (s == 0) return 32'h0;
    r = data_m[s];
    for (int i = 0; i < NW; i++)
      if (wb_we_a[i] && wb_s_a[i] == s) r = wb_v_a[i];
    return r;
  endfunction

  function automatic logic exp_rdy(input phys_reg_t s);
    if (s == 0) return 1'b1;
    for (int i = 0; i < NW; i++)
      if (wb_we_a[i] && wb_s_a[i] == s) return 1'b1;
    return ready_m[s];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NP; p++) begin
        data_m[p]  = 32'h0;
        ready_m[p] = 1'b1;
      end
      conflict_m = 1'b0;
      for (int k = 0; k < NR; k++) begin
        reg1_m[k] = 32'h0;
        reg2_m[k] = 32'h0;
      end
    end else begin
      for (int k = 0; k < NR; k++) begin
        reg1_m[k] = exp_val(rs1_s_a[k]);
        reg2_m[k] = exp_val(rs2_s_a[k]);
      end
      conflict_m = 1'b0;
      for (int i = 0; i < NW; i++)
        for (int j = i + 1; j < NW; j++)
          if (wb_we_a[i] && wb_we_a[j] && wb_s_a[i] == wb_s_a[j] && wb_s_a[i] != 0)
            conflict_m = 1'b1;
      for (int i = 0; i < NW; i++)
        if (wb_we_a[i] && wb_s_a[i] != 0) begin
          data_m[wb_s_a[i]]  = wb_v_a[i];
          ready_m[wb_s_a[i]] = 1'b1;
        end
      for (int j = 0; j < NA; j++)
        if (alloc_en_a[j] && alloc_s_a[j] != 0) ready_m[alloc_s_a[j]] = 1'b0;
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (check_en && rst_n) begin
      for (int k = 0; k < NR; k++) begin
        checkOutput($sformatf("cmp_rs1_v_comb[%0d]", k), rs1_v0[k*32 +: 32], exp_val(rs1_s_a[k]));
        checkOutput($sformatf("cmp_rs2_v_comb[%0d]", k), rs2_v0[k*32 +: 32], exp_val(rs2_s_a[k]));
        checkOutput($sformatf("cmp_rs1_v_reg[%0d]", k),  rs1_v1[k*32 +: 32], reg1_m[k]);
        checkOutput($sformatf("cmp_rs2_v_reg[%0d]", k),  rs2_v1[k*32 +: 32], reg2_m[k]);
        checkOutput($sformatf("cmp_rs1_rdy0[%0d]", k), {31'h0, rs1_rdy0[k]}, {31'h0, exp_rdy(rs1_s_a[k])});
        checkOutput($sformatf("cmp_rs2_rdy0[%0d]", k), {31'h0, rs2_rdy0[k]}, {31'h0, exp_rdy(rs2_s_a[k])});
        checkOutput($sformatf("cmp_rs1_rdy1[%0d]", k), {31'h0, rs1_rdy1[k]}, {31'h0, exp_rdy(rs1_s_a[k])});
        checkOutput($sformatf("cmp_rs2_rdy1[%0d]", k), {31'h0, rs2_rdy1[k]}, {31'h0, exp_rdy(rs2_s_a[k])});
      end
      checkOutput("cmp_conflict0", {31'h0, conf0}, {31'h0, conflict_m});
      checkOutput("cmp_conflict1", {31'h0, conf1}, {31'h0, conflict_m});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clearWrites();
    for (int i = 0; i < NW; i++) begin
      wb_we_a[i] = 1'b0;
      wb_s_a[i]  = '0;
      wb_v_a[i]  = 32'h0;
    end
    for (int j = 0; j < NA; j++) begin
      alloc_en_a[j] = 1'b0;
      alloc_s_a[j]  = '0;
    end
  endtask

  task automatic applyStimulus(input int port, input logic we, input phys_reg_t s, input logic [31:0] v);
    wb_we_a[port] = we;
    wb_s_a[port]  = s;
    wb_v_a[port]  = v;
  endtask

  initial begin
    clearWrites();
    for (int k = 0; k < NR; k++) begin
      rs1_s_a[k] = '0;
      rs2_s_a[k] = '0;
    end

    // Asynchronous reset pulse, released mid-cycle.
    #3 rst_n = 1'b0;
    #14 rst_n = 1'b1;
    rs1_s_a[0] = 6'd5;
    #1;
    checkOutput("reset_rs1_v",      rs1_v0[31:0], 32'h0);
    checkOutput("reset_rs1_rdy",    {31'h0, rs1_rdy0[0]}, 32'h1);
    checkOutput("reset_conflict",   {31'h0, conf0}, 32'h0);
    checkOutput("reset_rs1_v_reg",  rs1_v1[31:0], 32'h0);
    check_en = 1'b1;

    // Allocate p7, then write it back.
    alloc_en_a[0] = 1'b1;
    alloc_s_a[0]  = 6'd7;
    rs1_s_a[0]    = 6'd7;
    tick();
    clearWrites();
    #1;
    checkOutput("alloc_rdy_low", {31'h0, rs1_rdy0[0]}, 32'h0);
    applyStimulus(0, 1'b1, 6'd7, 32'hDEADBEEF);
    #1;
    checkOutput("wb_bypass_rdy",  {31'h0, rs1_rdy0[0]}, 32'h1);
    checkOutput("wb_bypass_data", rs1_v0[31:0], 32'hDEADBEEF);
    tick();
    clearWrites();
    #1;
    checkOutput("wb_array_data", rs1_v0[31:0], 32'hDEADBEEF);
    checkOutput("wb_array_rdy",  {31'h0, rs1_rdy0[0]}, 32'h1);
    checkOutput("wb_reg_data",   rs1_v1[31:0], 32'hDEADBEEF);

    // Same-cycle bypass on read port rs2.
    applyStimulus(0, 1'b1, 6'd9, 32'h1234);
    rs2_s_a[0] = 6'd9;
    #1;
    checkOutput("bypass_rs2_v",   rs2_v0[31:0], 32'h1234);
    checkOutput("bypass_rs2_rdy", {31'h0, rs2_rdy0[0]}, 32'h1);
    tick();
    clearWrites();
    #1;
    checkOutput("bypass_rs2_v_reg", rs2_v1[31:0], 32'h1234);

    // p0 ignores writes and allocation.
    applyStimulus(0, 1'b1, 6'd0, 32'hFFFFFFFF);
    alloc_en_a[0] = 1'b1;
    alloc_s_a[0]  = 6'd0;
    rs1_s_a[0]    = 6'd0;
    #1;
    checkOutput("p0_bypass_v", rs1_v0[31:0], 32'h0);
    tick();
    clearWrites();
    #1;
    checkOutput("p0_v",     rs1_v0[31:0], 32'h0);
    checkOutput("p0_rdy",   {31'h0, rs1_rdy0[0]}, 32'h1);
    checkOutput("p0_v_reg", rs1_v1[31:0], 32'h0);

    // Two writebacks and an allocation on p12 together.
    applyStimulus(0, 1'b1, 6'd12, 32'hAA);
    applyStimulus(1, 1'b1, 6'd12, 32'hBB);
    alloc_en_a[0] = 1'b1;
    alloc_s_a[0]  = 6'd12;
    rs1_s_a[0]    = 6'd12;
    #1;
    checkOutput("coll_bypass_v", rs1_v0[31:0], 32'hBB);
    tick();
    clearWrites();
    #1;
    checkOutput("coll_data",     rs1_v0[31:0], 32'hBB);
    checkOutput("coll_rdy",      {31'h0, rs1_rdy0[0]}, 32'h0);
    checkOutput("coll_conflict", {31'h0, conf0}, 32'h1);
    tick();
    checkOutput("coll_conflict_clear", {31'h0, conf0}, 32'h0);

    // Four writebacks over two cycles, then all four reads at once.
    applyStimulus(0, 1'b1, 6'd20, 32'h111);
    applyStimulus(1, 1'b1, 6'd21, 32'h222);
    tick();
    applyStimulus(0, 1'b1, 6'd22, 32'h333);
    applyStimulus(1, 1'b1, 6'd23, 32'h444);
    tick();
    clearWrites();
    rs1_s_a[0] = 6'd20; rs1_s_a[1] = 6'd21;
    rs2_s_a[0] = 6'd22; rs2_s_a[1] = 6'd23;
    #1;
    checkOutput("multi_rs1_0", rs1_v0[31:0],  32'h111);
    checkOutput("multi_rs1_1", rs1_v0[63:32], 32'h222);
    checkOutput("multi_rs2_0", rs2_v0[31:0],  32'h333);
    checkOutput("multi_rs2_1", rs2_v0[63:32], 32'h444);
    tick();
    checkOutput("multi_reg_rs1_1", rs1_v1[63:32], 32'h222);
    checkOutput("multi_reg_rs2_1", rs2_v1[63:32], 32'h444);

    // Mixed traffic over a small index range to provoke overlaps.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NW; i++)
        applyStimulus(i, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 15)), $urandom);
      alloc_en_a[0] = 1'($urandom_range(0, 1));
      alloc_s_a[0]  = 6'($urandom_range(0, 15));
      for (int k = 0; k < NR; k++) begin
        rs1_s_a[k] = 6'($urandom_range(0, 15));
        rs2_s_a[k] = 6'($urandom_range(0, 15));
      end
      tick();
    end
    clearWrites();

    // Reset mid-cycle wipes contents without a clock edge.
    applyStimulus(0, 1'b1, 6'd30, 32'h55);
    rs1_s_a[0] = 6'd7;
    rs2_s_a[0] = 6'd30;
    tick();
    clearWrites();
    check_en = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_p30_v",   rs2_v0[31:0], 32'h0);
    checkOutput("midreset_p7_rdy",  {31'h0, rs1_rdy0[0]}, 32'h1);
    checkOutput("midreset_v_reg",   rs2_v1[31:0], 32'h0);
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("postreset_p30_v", rs2_v0[31:0], 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
